// File: rtl/tetris_pkg.sv
// Board geometry, cell word type and row-fetch state encoding shared by the
// row fetcher, colour mapper and game logic.
package tetris_pkg;

  localparam int ROW_CELLS  = 10;
  localparam int BOARD_ROWS = 20;

  typedef logic [15:0] cell_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FETCH = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fifo_pop_ctrl.sv
// Read-FIFO pop pacing: issues up to ROW_CELLS pops, never more than the FIFO holds,
// and tracks which returned word lands in which cell. rd_req is combinational on rd_use.
module fifo_pop_ctrl #(
  parameter int ROW_CELLS = 10,
  parameter int IDX_W     = $clog2(ROW_CELLS + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clr,
  input  logic             en,
  input  logic [15:0]      rd_use,
  output logic             rd_req,
  output logic             capture,
  output logic [IDX_W-1:0] cap_idx
);

  logic [IDX_W-1:0] issued_q, issued_d;
  logic [IDX_W-1:0] cap_idx_q, cap_idx_d;
  logic             inflight_q, inflight_d;

  // rd_use does not yet reflect last cycle's pop, so that word is discounted.
  always_comb begin
    rd_req     = en && (issued_q < IDX_W'(ROW_CELLS)) && (rd_use > {15'd0, inflight_q});
    issued_d   = issued_q;
    cap_idx_d  = cap_idx_q;
    inflight_d = rd_req;
    if (clr) begin
      issued_d   = '0;
      cap_idx_d  = '0;
      inflight_d = 1'b0;
    end else begin
      if (rd_req)     issued_d  = issued_q + IDX_W'(1);
      if (inflight_q) cap_idx_d = cap_idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      issued_q   <= '0;
      cap_idx_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      issued_q   <= issued_d;
      cap_idx_q  <= cap_idx_d;
      inflight_q <= inflight_d;
    end
  end

  assign capture = inflight_q;
  assign cap_idx = cap_idx_q;

endmodule

// File: rtl/board_row_fetch.sv
// Fetches one playfield row from the SDRAM read FIFO into a parallel row buffer.
// Minimum 13 cycles request-to-ready; requests arriving mid-fetch queue as one pending (latest wins).
module board_row_fetch #(
  parameter int          ROW_CELLS   = tetris_pkg::ROW_CELLS,
  parameter int          BOARD_ROWS  = tetris_pkg::BOARD_ROWS,
  parameter logic [24:0] BASE_ADDR   = 25'h0,
  parameter int          STRIDE_LOG2 = 4,
  parameter int          TIMEOUT     = 1024
) (
  input  logic                                Clk,
  input  logic                                Reset,
  input  logic                                row_ld,
  input  logic [7:0]                          row_num,
  output logic                                row_ready,
  output logic                                row_err,
  output tetris_pkg::cell_t [ROW_CELLS-1:0]   row_data,
  output logic [24:0]                         rd_addr,
  output logic                                rd_load,
  output logic                                rd_req,
  input  logic [15:0]                         rd_data,
  input  logic [15:0]                         rd_use
);
  import tetris_pkg::*;

  localparam int IDX_W = $clog2(ROW_CELLS + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  fetch_state_t            state_q, state_d;
  logic [7:0]              row_q, row_d;
  logic [7:0]              pend_num_q, pend_num_d;
  logic                    pend_q, pend_d;
  logic                    row_ready_q, row_ready_d;
  logic                    row_err_q, row_err_d;
  logic                    rd_load_q, rd_load_d;
  logic [24:0]             rd_addr_q, rd_addr_d;
  cell_t [ROW_CELLS-1:0]   row_data_q, row_data_d;
  logic [TO_W-1:0]         to_q, to_d;

  logic                    pop_clr, pop_en, capture, timeout_hit, accept;
  logic [IDX_W-1:0]        cap_idx;
  logic [7:0]              ld_num;

  function automatic logic in_range(input logic [7:0] n);
    return int'(n) < BOARD_ROWS;
  endfunction

  function automatic logic [24:0] row_addr(input logic [7:0] n);
    return BASE_ADDR + (25'(n) << STRIDE_LOG2);
  endfunction

  fifo_pop_ctrl #(
    .ROW_CELLS (ROW_CELLS),
    .IDX_W     (IDX_W)
  ) u_pop (
    .Clk     (Clk),
    .Reset   (Reset),
    .clr     (pop_clr),
    .en      (pop_en),
    .rd_use  (rd_use),
    .rd_req  (rd_req),
    .capture (capture),
    .cap_idx (cap_idx)
  );

  assign timeout_hit = (state_q == FETCH) && !capture && (to_q == TO_W'(TIMEOUT - 1));
  assign pop_clr     = (state_q == LOAD);
  assign pop_en      = (state_q == FETCH) && !timeout_hit;
  // A fresh request overrides the stored one when both are present in DONE.
  assign ld_num      = row_ld ? row_num : pend_num_q;
  assign accept      = ((state_q == IDLE) || (state_q == DONE)) && (row_ld || pend_q);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    pend_d      = pend_q;
    pend_num_d  = pend_num_q;
    row_ready_d = row_ready_q;
    row_err_d   = row_err_q;
    rd_load_d   = 1'b0;
    rd_addr_d   = rd_addr_q;
    row_data_d  = row_data_q;
    to_d        = to_q;

    if (accept) begin
      row_d       = ld_num;
      pend_d      = 1'b0;
      row_ready_d = 1'b0;
      row_err_d   = 1'b0;
      state_d     = LOAD;
      if (in_range(ld_num)) begin
        rd_load_d = 1'b1;
        rd_addr_d = row_addr(ld_num);
      end
    end

    case (state_q)
      LOAD: begin
        row_data_d = '0;
        to_d       = '0;
        if (in_range(row_q)) begin
          state_d = FETCH;
        end else begin
          state_d     = DONE;
          row_ready_d = 1'b1;
        end
      end
      FETCH: begin
        to_d = capture ? '0 : to_q + TO_W'(1);
        for (int i = 0; i < ROW_CELLS; i++) begin
          if (capture && (cap_idx == IDX_W'(i))) row_data_d[i] = rd_data;
        end
        if (capture && (cap_idx == IDX_W'(ROW_CELLS - 1))) begin
          state_d     = DONE;
          row_ready_d = 1'b1;
        end else if (timeout_hit) begin
          state_d     = DONE;
          row_ready_d = 1'b1;
          row_err_d   = 1'b1;
        end
      end
      default: ;
    endcase

    if (((state_q == LOAD) || (state_q == FETCH)) && row_ld) begin
      pend_d     = 1'b1;
      pend_num_d = row_num;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      pend_q      <= 1'b0;
      pend_num_q  <= '0;
      row_ready_q <= 1'b0;
      row_err_q   <= 1'b0;
      rd_load_q   <= 1'b0;
      rd_addr_q   <= BASE_ADDR;
      row_data_q  <= '0;
      to_q        <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      pend_q      <= pend_d;
      pend_num_q  <= pend_num_d;
      row_ready_q <= row_ready_d;
      row_err_q   <= row_err_d;
      rd_load_q   <= rd_load_d;
      rd_addr_q   <= rd_addr_d;
      row_data_q  <= row_data_d;
      to_q        <= to_d;
    end
  end

  assign row_ready = row_ready_q;
  assign row_err   = row_err_q;
  assign row_data  = row_data_q;
  assign rd_addr   = rd_addr_q;
  assign rd_load   = rd_load_q;

endmodule

// File: tb/tb_board_row_fetch.sv
// Bench for board_row_fetch: FIFO model with lagging fill level, row scoreboard,
// table of fetch vectors plus pending-request and mid-fetch reset sequences.
module tb_board_row_fetch;
  localparam int NC = 10;

  typedef struct packed {
    logic            err;
    logic [NC*16-1:0] cells;
  } exp_t;

  typedef struct {
    int          row;
    int          fill;
    int          gap;
    logic [15:0] base;
    logic [24:0] addr;
    int          lat;
    int          loads;
    int          pops;
  } vec_t;

  logic                 Clk = 1'b0;
  logic                 Reset, row_ld;
  logic [7:0]           row_num;
  logic                 row_ready, row_err;
  logic [NC-1:0][15:0]  row_data;
  logic [24:0]          rd_addr;
  logic                 rd_load, rd_req;
  logic [15:0]          rd_data, rd_use;

  int errors = 0, checks = 0, cyc = 0, rises = 0, rise_cyc = 0;
  int pops = 0, loads = 0, underflows = 0, collisions = 0;
  int fill_words = 0, fill_gap = 0, fill_left = 0, gap_cnt = 0;
  logic [15:0] word_base = '0, next_word = '0;
  logic [15:0] fifo_q[$];
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic        ready_prev = 1'b0;
  logic        s_req, s_load;

  board_row_fetch dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .row_ld    (row_ld),
    .row_num   (row_num),
    .row_ready (row_ready),
    .row_err   (row_err),
    .row_data  (row_data),
    .rd_addr   (rd_addr),
    .rd_load   (rd_load),
    .rd_req    (rd_req),
    .rd_data   (rd_data),
    .rd_use    (rd_use)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Read-FIFO model: rd_load clears and refills, rd_use lags pops by one cycle.
  initial begin
    rd_data = '0;
    rd_use  = '0;
    forever begin
      @(posedge Clk);
      s_req  = rd_req;
      s_load = rd_load;
      #1;
      if (s_req) begin
        pops++;
        if (fifo_q.size() == 0) underflows++;
        else rd_data = fifo_q.pop_front();
      end
      if (s_load) begin
        loads++;
        fifo_q.delete();
        fill_left = fill_words;
        gap_cnt   = 0;
        next_word = word_base;
        if (fill_gap == 0) begin
          while (fill_left > 0) begin
            fifo_q.push_back(next_word);
            next_word++;
            fill_left--;
          end
        end
      end else if (fill_gap != 0 && fill_left > 0) begin
        gap_cnt++;
        if (gap_cnt == fill_gap) begin
          gap_cnt = 0;
          fifo_q.push_back(next_word);
          next_word++;
          fill_left--;
        end
      end
      rd_use = 16'(fifo_q.size()) + {15'd0, s_req};
    end
  end

  // Output monitor: every rising row_ready consumes one expected row.
  always @(negedge Clk) begin
    if (rd_req && rd_load) collisions++;
    if (row_ready && !ready_prev) begin
      rise_cyc = cyc;
      rises++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL row_out: unexpected row_ready at cycle %0d", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        if (row_data !== mon_e.cells || row_err !== mon_e.err) begin
          errors++;
          $display("FAIL row_out: got err=%0b data=%h, expected err=%0b data=%h",
                   row_err, row_data, mon_e.err, mon_e.cells);
        end
      end
    end
    ready_prev = row_ready;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t make_exp(input int row, input int fill, input logic [15:0] base);
    exp_t e;
    e = '0;
    if (row < 20) begin
      for (int k = 0; k < NC; k++)
        if (k < fill) e.cells[k*16 +: 16] = base + 16'(k);
      e.err = (fill < NC);
    end
    return e;
  endfunction

  task automatic do_req(input logic [7:0] n);
    row_ld  = 1'b1;
    row_num = n;
    @(posedge Clk);
    #1;
    row_ld  = 1'b0;
  endtask

  task automatic wait_ready(input string name, output bit ok);
    int r0;
    r0 = rises;
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge Clk);
      if (rises != r0) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: row_ready never rose, got 0 expected 1", name);
    end
  endtask

  initial begin
    vec_t vecs[7];
    int   start, l0, p0;
    bit   ok;

    vecs[0] = '{3,  10, 0, 16'h0001, 25'h030, 13, 1, 10};
    vecs[1] = '{0,  14, 0, 16'h0100, 25'h000, 13, 1, 10};
    vecs[2] = '{19, 10, 5, 16'h0200, 25'h130, 0,  1, 10};
    vecs[3] = '{25, 10, 0, 16'h0300, 25'h130, 2,  0, 0};
    vecs[4] = '{20, 10, 0, 16'h0300, 25'h130, 2,  0, 0};
    vecs[5] = '{4,  4,  0, 16'h0400, 25'h040, 0,  1, 4};
    vecs[6] = '{1,  10, 0, 16'h0500, 25'h010, 13, 1, 10};

    Reset   = 1'b1;
    row_ld  = 1'b0;
    row_num = '0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    chk("reset_row_ready", row_ready, 0);
    chk("reset_row_err", row_err, 0);
    chk("reset_rd_load", rd_load, 0);
    chk("reset_rd_req", rd_req, 0);
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_row_data_nonzero", row_data != '0, 0);

    for (int i = 0; i < 7; i++) begin
      fill_words = vecs[i].fill;
      fill_gap   = vecs[i].gap;
      word_base  = vecs[i].base;
      l0 = loads;
      p0 = pops;
      sb_q.push_back(make_exp(vecs[i].row, vecs[i].fill, vecs[i].base));
      start = cyc;
      do_req(8'(vecs[i].row));
      wait_ready($sformatf("v%0d_ready", i), ok);
      if (ok && vecs[i].lat != 0)
        chk($sformatf("v%0d_latency", i), 64'(rise_cyc - start), 64'(vecs[i].lat));
      repeat (3) @(posedge Clk);
      #1;
      chk($sformatf("v%0d_rd_addr", i), rd_addr, vecs[i].addr);
      chk($sformatf("v%0d_loads", i), 64'(loads - l0), 64'(vecs[i].loads));
      chk($sformatf("v%0d_pops", i), 64'(pops - p0), 64'(vecs[i].pops));
      chk($sformatf("v%0d_ready_held", i), row_ready, 1);
    end

    // Two requests during a row-2 fetch: only the later one (row 7) runs.
    fill_words = 10;
    fill_gap   = 0;
    word_base  = 16'h0800;
    l0 = loads;
    p0 = pops;
    sb_q.push_back(make_exp(2, 10, 16'h0800));
    sb_q.push_back(make_exp(7, 10, 16'h0800));
    do_req(8'd2);
    @(posedge Clk);
    #1;
    row_ld  = 1'b1;
    row_num = 8'd5;
    @(posedge Clk);
    #1;
    row_num = 8'd7;
    @(posedge Clk);
    #1;
    row_ld = 1'b0;
    wait_ready("pend_first_ready", ok);
    chk("pend_ready_one_cycle", row_ready, 0);
    wait_ready("pend_second_ready", ok);
    repeat (2) @(posedge Clk);
    #1;
    chk("pend_rd_addr", rd_addr, 25'h070);
    chk("pend_loads", 64'(loads - l0), 2);
    chk("pend_pops", 64'(pops - p0), 20);

    // Reset after four captures of a slow fetch, then a normal fetch.
    fill_words = 10;
    fill_gap   = 5;
    word_base  = 16'h0600;
    p0 = pops;
    do_req(8'd6);
    for (int k = 0; k < 300 && (pops - p0) < 4; k++) begin
      @(posedge Clk);
      #2;
    end
    @(posedge Clk);
    #1;
    chk("mid_cell3", row_data[3], 16'h0603);
    Reset = 1'b1;
    #1;
    chk("mid_rst_row_ready", row_ready, 0);
    chk("mid_rst_row_err", row_err, 0);
    chk("mid_rst_rd_req", rd_req, 0);
    chk("mid_rst_rd_load", rd_load, 0);
    chk("mid_rst_rd_addr", rd_addr, 0);
    chk("mid_rst_row_data_nonzero", row_data != '0, 0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    fill_gap  = 0;
    word_base = 16'h0700;
    sb_q.push_back(make_exp(8, 10, 16'h0700));
    start = cyc;
    do_req(8'd8);
    wait_ready("post_rst_ready", ok);
    if (ok) chk("post_rst_latency", 64'(rise_cyc - start), 13);
    chk("post_rst_rd_addr", rd_addr, 25'h080);

    repeat (3) @(posedge Clk);
    #1;
    chk("sb_leftover", 64'(sb_q.size()), 0);
    chk("fifo_underflows", 64'(underflows), 0);
    chk("load_req_collisions", 64'(collisions), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
